// File: rtl/regfile_sb.sv
// regfile_sb -- register file with a per-register scoreboard (busy bits).
//
// Two combinational read ports with write-through bypass, one writeback
// port, and one reservation port that marks a destination as pending until
// its result is written back. Register 0 is hard-wired to zero and is never
// pending.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   s1sel/s2sel -> s1/s2 read selects and combinational read data
//   s1_busy/s2_busy     selected source has an unwritten result pending
//   wen, dsel, d        writeback enable, destination, data
//   rsv_en, rsv_sel     reservation request and target register
//   rsv_ok              reservation accepted this cycle (combinational)
//   pend_cnt            registered count of pending registers
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   s1sel,
  input  logic [AW-1:0]   s2sel,
  output logic [XLEN-1:0] s1,
  output logic [XLEN-1:0] s2,
  output logic            s1_busy,
  output logic            s2_busy,
  input  logic            wen,
  input  logic [AW-1:0]   dsel,
  input  logic [XLEN-1:0] d,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_sel,
  output logic            rsv_ok,
  output logic [AW:0]     pend_cnt
);

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy;   // bit 0 is never set

  logic wr_hit;    // a real write (x0 excluded)
  logic rsv_set;   // accepted reservation of a real register
  logic cnt_up;
  logic cnt_dn;

  assign wr_hit = wen && (dsel != '0);

  // Write-through reads: a same-cycle write to the selected register wins.
  assign s1 = (wr_hit && dsel == s1sel) ? d : regs[s1sel];
  assign s2 = (wr_hit && dsel == s2sel) ? d : regs[s2sel];

  // A source being written this cycle is not busy: the bypass supplies it.
  assign s1_busy = (s1sel != '0) && busy[s1sel] && !(wen && dsel == s1sel);
  assign s2_busy = (s2sel != '0) && busy[s2sel] && !(wen && dsel == s2sel);

  // A pending register can be re-reserved in the cycle its old result retires.
  assign rsv_ok  = rsv_en && ((rsv_sel == '0) || !busy[rsv_sel] ||
                              (wen && dsel == rsv_sel));
  assign rsv_set = rsv_ok && (rsv_sel != '0);

  // Count only real 0->1 and 1->0 transitions of busy bits. A release and
  // re-reservation of the same register leaves the bit, and the count, at 1.
  assign cnt_up = rsv_set && !busy[rsv_sel];
  assign cnt_dn = wr_hit && busy[dsel] && !(rsv_set && rsv_sel == dsel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs     <= '0;
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      if (wr_hit) begin
        regs[dsel] <= d;
        busy[dsel] <= 1'b0;
      end
      // Reservation is applied after the release so it wins on a collision.
      if (rsv_set) busy[rsv_sel] <= 1'b1;
      if (cnt_up && !cnt_dn)      pend_cnt <= pend_cnt + (AW+1)'(1);
      else if (cnt_dn && !cnt_up) pend_cnt <= pend_cnt - (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   s1sel = '0, s2sel = '0, dsel = '0, rsv_sel = '0;
  logic [XLEN-1:0] s1, s2, d = '0;
  logic            s1_busy, s2_busy, rsv_ok;
  logic            wen = 1'b0, rsv_en = 1'b0;
  logic [AW:0]     pend_cnt;

  int  n_chk = 0;
  int  n_err = 0;
  bit  chk_en = 1'b0;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s1sel(s1sel), .s2sel(s2sel), .s1(s1), .s2(s2),
    .s1_busy(s1_busy), .s2_busy(s2_busy),
    .wen(wen), .dsel(dsel), .d(d),
    .rsv_en(rsv_en), .rsv_sel(rsv_sel), .rsv_ok(rsv_ok),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [XLEN-1:0] mregs [NREGS];
  bit              mbusy [NREGS];

  function automatic logic [XLEN-1:0] exp_s(input logic [AW-1:0] sel);
    if (wen && dsel != 0 && dsel == sel) return d;
    if (sel == 0) return '0;
    return mregs[sel];
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] sel);
    return (sel != 0) && mbusy[sel] && !(wen && dsel == sel);
  endfunction

  function automatic bit exp_ok();
    return rsv_en && (rsv_sel == 0 || !mbusy[rsv_sel] || (wen && dsel == rsv_sel));
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int i = 0; i < NREGS; i++) c += int'(mbusy[i]);
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin mregs[i] = '0; mbusy[i] = 1'b0; end
    end else begin
      bit ok;
      ok = exp_ok();
      if (wen && dsel != 0) begin mregs[dsel] = d; mbusy[dsel] = 1'b0; end
      if (ok && rsv_sel != 0) mbusy[rsv_sel] = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: DUT against model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("s1", s1, exp_s(s1sel));
      chk("s2", s2, exp_s(s2sel));
      chk("s1_busy", s1_busy, exp_busy(s1sel));
      chk("s2_busy", s2_busy, exp_busy(s2sel));
      chk("rsv_ok", rsv_ok, exp_ok());
      chk("pend_cnt", pend_cnt, exp_cnt());
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    wen = 0; dsel = '0; d = '0; rsv_en = 0; rsv_sel = '0;
  endtask

  initial begin
    logic [XLEN-1:0] v;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Reset state
    s1sel = 5; s2sel = 31; #1;
    chk("rst_s1", s1, 0); chk("rst_s2", s2, 0);
    chk("rst_s1_busy", s1_busy, 0); chk("rst_pend", pend_cnt, 0);
    cyc(); rst_n = 1'b1;
    cyc();

    // Write-through then storage read of x6
    wen = 1; dsel = 6; d = 32'hDEADBEEF; s1sel = 6; #1;
    chk("bypass_x6", s1, 32'hDEADBEEF);
    cyc(); idle(); #1;
    chk("stored_x6", s1, 32'hDEADBEEF);

    // x0 ignores writes and reservations
    wen = 1; dsel = 0; d = 32'h1234; s1sel = 0; #1;
    chk("x0_write_bypass", s1, 0);
    cyc(); idle(); rsv_en = 1; rsv_sel = 0; #1;
    chk("x0_read", s1, 0); chk("x0_rsv_ok", rsv_ok, 1);
    cyc(); idle(); #1;
    chk("x0_pend", pend_cnt, 0);

    // Reserve x7, reject second reservation, write to release
    rsv_en = 1; rsv_sel = 7; #1;
    chk("x7_rsv_ok", rsv_ok, 1);
    cyc(); idle(); s2sel = 7; #1;
    chk("x7_pend", pend_cnt, 1); chk("x7_busy", s2_busy, 1);
    rsv_en = 1; rsv_sel = 7; #1;
    chk("x7_rsv_rej", rsv_ok, 0);
    cyc(); idle(); #1;
    chk("x7_pend_hold", pend_cnt, 1);
    wen = 1; dsel = 7; d = 32'hA5; #1;
    chk("x7_bypass", s2, 32'hA5); chk("x7_busy_byp", s2_busy, 0);
    cyc(); idle(); #1;
    chk("x7_pend_clr", pend_cnt, 0); chk("x7_data", s2, 32'hA5);
    chk("x7_busy_clr", s2_busy, 0);

    // Release and re-reserve x28 in the same cycle
    rsv_en = 1; rsv_sel = 28; cyc(); idle(); #1;
    chk("x28_pend", pend_cnt, 1);
    wen = 1; dsel = 28; d = 32'h2828_0001; rsv_en = 1; rsv_sel = 28; s1sel = 28; #1;
    chk("x28_rsv_ok", rsv_ok, 1); chk("x28_bypass", s1, 32'h2828_0001);
    cyc(); idle(); #1;
    chk("x28_pend_hold", pend_cnt, 1); chk("x28_busy", s1_busy, 1);
    chk("x28_data", s1, 32'h2828_0001);

    // Randomized phase, biased toward select collisions
    for (int n = 0; n < 3000; n++) begin
      wen    = ($urandom_range(0, 2) != 0);
      dsel   = AW'($urandom);
      d      = $urandom;
      rsv_en = ($urandom_range(0, 2) != 0);
      rsv_sel = ($urandom_range(0, 3) == 0) ? dsel : AW'($urandom);
      s1sel  = ($urandom_range(0, 3) == 0) ? dsel : AW'($urandom);
      s2sel  = ($urandom_range(0, 3) == 0) ? rsv_sel : AW'($urandom);
      cyc();
    end

    // Retire everything, then reserve x1..x31 (each with a data write)
    idle();
    for (int i = 1; i < NREGS; i++) begin
      wen = 1; dsel = AW'(i); d = 32'h1111 * i; cyc();
    end
    idle(); #1;
    chk("drain_pend", pend_cnt, 0);
    for (int i = 1; i < NREGS; i++) begin
      rsv_en = 1; rsv_sel = AW'(i); wen = 1; dsel = AW'(i); d = 32'h0101 * i; cyc();
    end
    idle(); #1;
    chk("all_pend", pend_cnt, 31);
    s1sel = 9; #1;
    chk("x9_before_rst", s1, 32'h0909);

    // Asynchronous reset pulse between edges
    rst_n = 1'b0; #1;
    chk("async_pend", pend_cnt, 0);
    for (int i = 0; i < NREGS; i++) begin
      s1sel = AW'(i); s2sel = AW'(i); #1;
      chk("rst_reg", s1, 0); chk("rst_busy", s1_busy, 0);
    end
    @(negedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #1;

    // First write after reset is accepted at the first edge
    wen = 1; dsel = 3; d = 32'hCAFE_0003; cyc(); idle(); s1sel = 3; #1;
    v = s1;
    chk("first_write", v, 32'hCAFE_0003);
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
